// File: rtl/interp_pkg.sv
// ============================================================================
// Module   : interp_pkg
// Brief    : Shared widths, weight helper and stage-control record for the
//            bilinear interpolator pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package interp_pkg;

  function automatic int frac_one(int frac_w);
    return 1 << frac_w;
  endfunction

  function automatic int lerp_w(int pix_w, int frac_w);
    return pix_w + frac_w;
  endfunction

  function automatic int acc_w(int pix_w, int frac_w);
    return pix_w + 2 * frac_w;
  endfunction

  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

endpackage

`default_nettype wire

// File: rtl/bilinear_interp_pipe_if.sv
// ============================================================================
// Module   : bilinear_interp_pipe_if
// Brief    : Input/output stream bundle of the bilinear interpolator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bilinear_interp_pipe_if #(
  parameter int PIX_W    = 8,
  parameter int FRAC_W   = 6,
  parameter int CHANNELS = 1
);

  logic                      s_valid;
  logic                      s_ready;
  logic [FRAC_W-1:0]         s_dx;
  logic [FRAC_W-1:0]         s_dy;
  logic [CHANNELS*PIX_W-1:0] s_lu;
  logic [CHANNELS*PIX_W-1:0] s_ru;
  logic [CHANNELS*PIX_W-1:0] s_ld;
  logic [CHANNELS*PIX_W-1:0] s_rd;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [CHANNELS*PIX_W-1:0] m_p;
  logic                      m_last;

  modport slave (
    input  s_valid, s_dx, s_dy, s_lu, s_ru, s_ld, s_rd, s_last, m_ready,
    output s_ready, m_valid, m_p, m_last
  );

  modport master (
    output s_valid, s_dx, s_dy, s_lu, s_ru, s_ld, s_rd, s_last, m_ready,
    input  s_ready, m_valid, m_p, m_last
  );

endinterface

`default_nettype wire

// File: rtl/interp_lerp.sv
// ============================================================================
// Module   : interp_lerp
// Brief    : Combinational unsigned lerp y = a*(2**FRAC_W - f) + b*f.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_lerp #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 6
) (
  input  logic [IN_W-1:0]        a,
  input  logic [IN_W-1:0]        b,
  input  logic [FRAC_W-1:0]      f,
  output logic [IN_W+FRAC_W-1:0] y
);

  localparam int OUT_W = IN_W + FRAC_W;

  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] f_ext;
  logic [OUT_W-1:0] a_hi;

  assign a_ext = {{FRAC_W{1'b0}}, a};
  assign b_ext = {{FRAC_W{1'b0}}, b};
  assign f_ext = {{IN_W{1'b0}}, f};
  assign a_hi  = {a, {FRAC_W{1'b0}}};

  // a*(W1-f) expanded to a*W1 - a*f keeps every term within OUT_W bits;
  // the true result always fits, so modular wrap of the partial sum is harmless.
  assign y = a_hi - a_ext * f_ext + b_ext * f_ext;

endmodule

`default_nettype wire

// File: rtl/bilinear_interp_pipe.sv
// ============================================================================
// Module   : bilinear_interp_pipe
// Brief    : Pipelined multi-lane bilinear interpolator with valid/ready flow.
//            Define INTERP_ROUND_EN for round-half-up output, else floor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bilinear_interp_pipe
  import interp_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int FRAC_W   = 6,
  parameter int CHANNELS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bilinear_interp_pipe_if.slave  bus
);

  localparam int LERP_W = lerp_w(PIX_W, FRAC_W);
  localparam int ACC_W  = acc_w(PIX_W, FRAC_W);
  localparam int BUS_W  = CHANNELS * PIX_W;

  logic advance;
  logic accept;
  logic ready_en_q, ready_en_d;

  stage_ctl_t ctl0_q, ctl0_d;
  stage_ctl_t ctl1_q, ctl1_d;
  stage_ctl_t ctl2_q, ctl2_d;
  stage_ctl_t ctl3_q, ctl3_d;

  logic [FRAC_W-1:0] dx0_q, dx0_d;
  logic [FRAC_W-1:0] dy0_q, dy0_d;
  logic [FRAC_W-1:0] dy1_q, dy1_d;
  logic [BUS_W-1:0]  lu0_q, lu0_d;
  logic [BUS_W-1:0]  ru0_q, ru0_d;
  logic [BUS_W-1:0]  ld0_q, ld0_d;
  logic [BUS_W-1:0]  rd0_q, rd0_d;

  logic [LERP_W-1:0] t1_q [CHANNELS];
  logic [LERP_W-1:0] t1_d [CHANNELS];
  logic [LERP_W-1:0] b1_q [CHANNELS];
  logic [LERP_W-1:0] b1_d [CHANNELS];
  logic [LERP_W-1:0] t_n  [CHANNELS];
  logic [LERP_W-1:0] b_n  [CHANNELS];
  logic [ACC_W-1:0]  v2_q [CHANNELS];
  logic [ACC_W-1:0]  v2_d [CHANNELS];
  logic [ACC_W-1:0]  v_n  [CHANNELS];
  logic [PIX_W-1:0]  p_n  [CHANNELS];
  logic [BUS_W-1:0]  m_p_q, m_p_d;

  // Every stage moves together; bubbles are kept so timing stays fixed.
  assign advance     = !ctl3_q.valid || bus.m_ready;
  assign bus.s_ready = advance && ready_en_q;
  assign accept      = bus.s_valid && bus.s_ready;

  assign bus.m_valid = ctl3_q.valid;
  assign bus.m_last  = ctl3_q.last;
  assign bus.m_p     = m_p_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    interp_lerp #(.IN_W(PIX_W), .FRAC_W(FRAC_W)) u_lerp_top (
      .a (lu0_q[k*PIX_W +: PIX_W]),
      .b (ru0_q[k*PIX_W +: PIX_W]),
      .f (dx0_q),
      .y (t_n[k])
    );

    interp_lerp #(.IN_W(PIX_W), .FRAC_W(FRAC_W)) u_lerp_bot (
      .a (ld0_q[k*PIX_W +: PIX_W]),
      .b (rd0_q[k*PIX_W +: PIX_W]),
      .f (dx0_q),
      .y (b_n[k])
    );

    interp_lerp #(.IN_W(LERP_W), .FRAC_W(FRAC_W)) u_lerp_vert (
      .a (t1_q[k]),
      .b (b1_q[k]),
      .f (dy1_q),
      .y (v_n[k])
    );

`ifdef INTERP_ROUND_EN
    localparam logic [ACC_W:0] HALF_LSB = (ACC_W+1)'(1) << (2*FRAC_W-1);
    logic [ACC_W:0] rnd_sum;
    logic           unused_rnd;
    assign rnd_sum    = {1'b0, v2_q[k]} + HALF_LSB;
    assign p_n[k]     = rnd_sum[2*FRAC_W +: PIX_W];
    assign unused_rnd = ^{rnd_sum[ACC_W], rnd_sum[2*FRAC_W-1:0]};
`else
    logic unused_frac;
    assign p_n[k]      = v2_q[k][2*FRAC_W +: PIX_W];
    assign unused_frac = ^v2_q[k][2*FRAC_W-1:0];
`endif
  end

  always_comb begin
    ready_en_d = 1'b1;
    ctl0_d = ctl0_q;
    ctl1_d = ctl1_q;
    ctl2_d = ctl2_q;
    ctl3_d = ctl3_q;
    dx0_d  = dx0_q;
    dy0_d  = dy0_q;
    dy1_d  = dy1_q;
    lu0_d  = lu0_q;
    ru0_d  = ru0_q;
    ld0_d  = ld0_q;
    rd0_d  = rd0_q;
    t1_d   = t1_q;
    b1_d   = b1_q;
    v2_d   = v2_q;
    m_p_d  = m_p_q;
    if (advance) begin
      ctl0_d = '{valid: accept, last: accept && bus.s_last};
      if (accept) begin
        dx0_d = bus.s_dx;
        dy0_d = bus.s_dy;
        lu0_d = bus.s_lu;
        ru0_d = bus.s_ru;
        ld0_d = bus.s_ld;
        rd0_d = bus.s_rd;
      end
      ctl1_d = ctl0_q;
      if (ctl0_q.valid) begin
        t1_d  = t_n;
        b1_d  = b_n;
        dy1_d = dy0_q;
      end
      ctl2_d = ctl1_q;
      if (ctl1_q.valid) begin
        v2_d = v_n;
      end
      ctl3_d = ctl2_q;
      if (ctl2_q.valid) begin
        for (int k = 0; k < CHANNELS; k++) begin
          m_p_d[k*PIX_W +: PIX_W] = p_n[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      ctl0_q     <= '0;
      ctl1_q     <= '0;
      ctl2_q     <= '0;
      ctl3_q     <= '0;
      dx0_q      <= '0;
      dy0_q      <= '0;
      dy1_q      <= '0;
      lu0_q      <= '0;
      ru0_q      <= '0;
      ld0_q      <= '0;
      rd0_q      <= '0;
      m_p_q      <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        t1_q[k] <= '0;
        b1_q[k] <= '0;
        v2_q[k] <= '0;
      end
    end else begin
      ready_en_q <= ready_en_d;
      ctl0_q     <= ctl0_d;
      ctl1_q     <= ctl1_d;
      ctl2_q     <= ctl2_d;
      ctl3_q     <= ctl3_d;
      dx0_q      <= dx0_d;
      dy0_q      <= dy0_d;
      dy1_q      <= dy1_d;
      lu0_q      <= lu0_d;
      ru0_q      <= ru0_d;
      ld0_q      <= ld0_d;
      rd0_q      <= rd0_d;
      m_p_q      <= m_p_d;
      t1_q       <= t1_d;
      b1_q       <= b1_d;
      v2_q       <= v2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bilinear_interp_pipe.sv
// ============================================================================
// Module   : tb_bilinear_interp_pipe
// Brief    : Self-checking bench: 1-lane and 3-lane instances against a
//            closed-form bilinear model (rounding follows INTERP_ROUND_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bilinear_interp_pipe;

  localparam int PIX_W  = 8;
  localparam int FRAC_W = 6;
  localparam int W1     = 64;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst3_n;
  always #5 clk = ~clk;

  bilinear_interp_pipe_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CHANNELS(1)) bus1 ();
  bilinear_interp_pipe_if #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CHANNELS(3)) bus3 ();

  bilinear_interp_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CHANNELS(1)) dut1 (
    .clk (clk), .rst_n (rst1_n), .bus (bus1)
  );
  bilinear_interp_pipe #(.PIX_W(PIX_W), .FRAC_W(FRAC_W), .CHANNELS(3)) dut3 (
    .clk (clk), .rst_n (rst3_n), .bus (bus3)
  );

  typedef struct {
    logic [23:0] p;
    logic        last;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    int dx, dy, lu, ru, ld, rd, p;
  } vec_t;

  exp_t        q1[$];
  exp_t        q3[$];
  exp_t        pend [2];
  logic        stall [2];
  logic [23:0] hold_p [2];
  logic        hold_l [2];
  int          acc_cnt [2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_lat = 0;
  vec_t        tbl [6];

  // Closed-form weighted sum of the four corners.
  function automatic int ref_pix(int dx, int dy, int lu, int ru, int ld, int rd);
    longint v;
    v = longint'(lu) * (W1 - dx) * (W1 - dy) + longint'(ru) * dx * (W1 - dy)
      + longint'(ld) * (W1 - dx) * dy + longint'(rd) * dx * dy;
`ifdef INTERP_ROUND_EN
    v = v + (W1 * W1) / 2;
`endif
    return int'(v / (W1 * W1));
  endfunction

  task automatic check(string name, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(int id, logic mv, logic mr, logic [23:0] mp, logic ml);
    exp_t e;
    int   sz;
    if (stall[id]) begin
      check("stall_valid", mv, 1);
      check("stall_p", mp, hold_p[id]);
      check("stall_last", ml, hold_l[id]);
    end
    sz = (id == 0) ? q1.size() : q3.size();
    if (mv) begin
      if (sz == 0) begin
        check("spurious_beat", mv, 0);
      end else if (mr) begin
        if (id == 0) e = q1.pop_front();
        else         e = q3.pop_front();
        check(id == 0 ? "pix_l1" : "pix_l3", mp, e.p);
        check("last", ml, e.last);
        if (chk_lat) check("latency", cyc - e.acc_cyc, 4);
      end
    end
    stall[id]  = mv && !mr;
    hold_p[id] = mp;
    hold_l[id] = ml;
  endtask

  task automatic tick();
    #1;
    if (rst1_n) begin
      mon(0, bus1.m_valid, bus1.m_ready, {16'b0, bus1.m_p}, bus1.m_last);
      if (bus1.s_valid && bus1.s_ready) begin
        pend[0].acc_cyc = cyc;
        q1.push_back(pend[0]);
        acc_cnt[0]++;
      end
    end else begin
      stall[0] = 1'b0;
    end
    if (rst3_n) begin
      mon(1, bus3.m_valid, bus3.m_ready, bus3.m_p, bus3.m_last);
      if (bus3.s_valid && bus3.s_ready) begin
        pend[1].acc_cyc = cyc;
        q3.push_back(pend[1]);
        acc_cnt[1]++;
      end
    end else begin
      stall[1] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive1(bit v, int dx, int dy, int lu, int ru, int ld, int rd, bit last, int p);
    bus1.s_valid = v;
    bus1.s_dx    = FRAC_W'(dx);
    bus1.s_dy    = FRAC_W'(dy);
    bus1.s_lu    = PIX_W'(lu);
    bus1.s_ru    = PIX_W'(ru);
    bus1.s_ld    = PIX_W'(ld);
    bus1.s_rd    = PIX_W'(rd);
    bus1.s_last  = last;
    pend[0].p    = 24'(p);
    pend[0].last = last;
  endtask

  task automatic rand1();
    int dx, dy, lu, ru, ld, rd;
    dx = $urandom_range(0, 63); dy = $urandom_range(0, 63);
    lu = $urandom_range(0, 255); ru = $urandom_range(0, 255);
    ld = $urandom_range(0, 255); rd = $urandom_range(0, 255);
    drive1(($urandom % 4) != 0, dx, dy, lu, ru, ld, rd, $urandom % 2,
           ref_pix(dx, dy, lu, ru, ld, rd));
    bus1.m_ready = ($urandom % 3) != 0;
  endtask

  task automatic rand3();
    int dx, dy, lu, ru, ld, rd;
    dx = $urandom_range(0, 63);
    dy = $urandom_range(0, 63);
    bus3.s_valid  = ($urandom % 4) != 0;
    bus3.s_dx     = FRAC_W'(dx);
    bus3.s_dy     = FRAC_W'(dy);
    bus3.s_last   = $urandom % 2;
    pend[1].last  = bus3.s_last;
    for (int k = 0; k < 3; k++) begin
      lu = $urandom_range(0, 255); ru = $urandom_range(0, 255);
      ld = $urandom_range(0, 255); rd = $urandom_range(0, 255);
      bus3.s_lu[k*8 +: 8] = 8'(lu);
      bus3.s_ru[k*8 +: 8] = 8'(ru);
      bus3.s_ld[k*8 +: 8] = 8'(ld);
      bus3.s_rd[k*8 +: 8] = 8'(rd);
      pend[1].p[k*8 +: 8] = 8'(ref_pix(dx, dy, lu, ru, ld, rd));
    end
    bus3.m_ready = ($urandom % 3) != 0;
  endtask

  task automatic idle_all();
    bus1.s_valid = 1'b0; bus1.m_ready = 1'b1;
    bus3.s_valid = 1'b0; bus3.m_ready = 1'b1;
  endtask

  task automatic drain(string name);
    int n;
    idle_all();
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check(name, q1.size() + q3.size(), 0);
  endtask

  initial begin
    tbl[0] = '{dx: 27, dy: 35, lu: 2,   ru: 4,   ld: 3,   rd: 4,   p: 3};
    tbl[1] = '{dx: 15, dy: 27, lu: 4,   ru: 6,   ld: 4,   rd: 6,   p: 4};
    tbl[2] = '{dx: 55, dy: 2,  lu: 129, ru: 129, ld: 138, rd: 138, p: 129};
`ifdef INTERP_ROUND_EN
    tbl[3] = '{dx: 32, dy: 0,  lu: 0,   ru: 1,   ld: 0,   rd: 1,   p: 1};
`else
    tbl[3] = '{dx: 32, dy: 0,  lu: 0,   ru: 1,   ld: 0,   rd: 1,   p: 0};
`endif
    tbl[4] = '{dx: 63, dy: 63, lu: 255, ru: 255, ld: 255, rd: 255, p: 255};
    tbl[5] = '{dx: 0,  dy: 0,  lu: 77,  ru: 200, ld: 13,  rd: 99,  p: 77};

    for (int i = 0; i < 2; i++) begin
      stall[i] = 1'b0; acc_cnt[i] = 0; hold_p[i] = '0; hold_l[i] = 1'b0;
    end
    drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus3.s_dx = '0; bus3.s_dy = '0; bus3.s_lu = '0; bus3.s_ru = '0;
    bus3.s_ld = '0; bus3.s_rd = '0; bus3.s_last = 1'b0;
    idle_all();
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    repeat (3) tick();

    check("rst_m_valid1", bus1.m_valid, 0);
    check("rst_m_p1", bus1.m_p, 0);
    check("rst_m_last1", bus1.m_last, 0);
    check("rst_m_valid3", bus3.m_valid, 0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    tick();
    check("s_ready_after_rst1", bus1.s_ready, 1);
    check("s_ready_after_rst3", bus3.s_ready, 1);

    // Directed vectors back-to-back with fixed latency expected for each.
    chk_lat = 1;
    for (int i = 0; i < 6; i++) begin
      drive1(1, tbl[i].dx, tbl[i].dy, tbl[i].lu, tbl[i].ru, tbl[i].ld, tbl[i].rd,
             i == 5, tbl[i].p);
      tick();
    end
    drain("drain_directed");
    chk_lat = 0;

    // Single stall: hold m_ready low for a few cycles with a beat at the head.
    drive1(1, 10, 20, 50, 60, 70, 80, 1, ref_pix(10, 20, 50, 60, 70, 80));
    tick();
    bus1.s_valid = 1'b0;
    bus1.m_ready = 1'b0;
    repeat (6) tick();
    check("stall_holds_valid", bus1.m_valid, 1);
    drain("drain_stall");

    // Random back-pressure, single lane.
    begin
      int n = 0;
      acc_cnt[0] = 0;
      while (acc_cnt[0] < 1000 && n < 20000) begin
        rand1();
        tick();
        n++;
      end
      check("rand1_accepted", acc_cnt[0], 1000);
    end
    drain("drain_rand1");

    // Three lanes, then reset mid-stream.
    begin
      int n = 0;
      acc_cnt[1] = 0;
      while (acc_cnt[1] < 200 && n < 5000) begin
        rand3();
        tick();
        n++;
      end
      check("rand3_accepted", acc_cnt[1], 200);
      n = 0;
      while (!bus3.m_valid && n < 50) begin
        rand3();
        tick();
        n++;
      end
    end
    rst3_n = 1'b0;
    #1;
    check("midrst_m_valid", bus3.m_valid, 0);
    check("midrst_m_p", bus3.m_p, 0);
    q3.delete();
    bus3.s_valid = 1'b0;
    bus3.m_ready = 1'b1;
    repeat (2) tick();
    rst3_n = 1'b1;
    repeat (10) begin
      tick();
      check("no_stale", bus3.m_valid, 0);
    end
    begin
      int n = 0;
      acc_cnt[1] = 0;
      while (acc_cnt[1] < 100 && n < 3000) begin
        rand3();
        tick();
        n++;
      end
      check("rand3_post_rst", acc_cnt[1], 100);
    end
    drain("drain_rand3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
